// File: rtl/riscv_core_rob2w_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_rob2w_if
// Description : Bundle of issue, writeback and retirement signals for the
//               2-wide reorder buffer.
//               master : issue/writeback side (drives requests and fills,
//                        observes grants and the retirement stream)
//               slave  : the reorder buffer itself
//               Ports  : alloc_A/B_{req,rd,rd_en} -> slave
//                        alloc_A/B_{slot,rdy}     <- slave
//                        fill_A/B_{val,slot}      -> slave
//                        commit_A/B_{ready,slot,rd,rd_en}, empty, count <- slave
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_core_rob2w_if #(
    parameter int SLOT_W = 5
);
    logic              alloc_A_req;
    logic [4:0]        alloc_A_rd;
    logic              alloc_A_rd_en;
    logic              alloc_B_req;
    logic [4:0]        alloc_B_rd;
    logic              alloc_B_rd_en;
    logic [SLOT_W-1:0] alloc_A_slot;
    logic [SLOT_W-1:0] alloc_B_slot;
    logic              alloc_A_rdy;
    logic              alloc_B_rdy;

    logic              fill_A_val;
    logic [SLOT_W-1:0] fill_A_slot;
    logic              fill_B_val;
    logic [SLOT_W-1:0] fill_B_slot;

    logic              commit_A_ready;
    logic [SLOT_W-1:0] commit_A_slot;
    logic [4:0]        commit_A_rd;
    logic              commit_A_rd_en;
    logic              commit_B_ready;
    logic [SLOT_W-1:0] commit_B_slot;
    logic [4:0]        commit_B_rd;
    logic              commit_B_rd_en;
    logic              empty;
    logic [SLOT_W:0]   count;

    modport master (
        output alloc_A_req, alloc_A_rd, alloc_A_rd_en,
        output alloc_B_req, alloc_B_rd, alloc_B_rd_en,
        input  alloc_A_slot, alloc_B_slot, alloc_A_rdy, alloc_B_rdy,
        output fill_A_val, fill_A_slot, fill_B_val, fill_B_slot,
        input  commit_A_ready, commit_A_slot, commit_A_rd, commit_A_rd_en,
        input  commit_B_ready, commit_B_slot, commit_B_rd, commit_B_rd_en,
        input  empty, count
    );

    modport slave (
        input  alloc_A_req, alloc_A_rd, alloc_A_rd_en,
        input  alloc_B_req, alloc_B_rd, alloc_B_rd_en,
        output alloc_A_slot, alloc_B_slot, alloc_A_rdy, alloc_B_rdy,
        input  fill_A_val, fill_A_slot, fill_B_val, fill_B_slot,
        output commit_A_ready, commit_A_slot, commit_A_rd, commit_A_rd_en,
        output commit_B_ready, commit_B_slot, commit_B_rd, commit_B_rd_en,
        output empty, count
    );
endinterface
`default_nettype wire

// File: rtl/riscv_core_rob2w.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_rob2w
// Description : 2-wide reorder buffer. Allocates up to two slots per cycle in
//               program order, marks slots complete on writeback and retires
//               up to two completed entries per cycle strictly in order.
//               Ports : clk   - core clock
//                       reset - synchronous active-high reset
//                       bus   - riscv_core_rob2w_if.slave (alloc/fill/commit)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_rob2w #(
    parameter int ENTRIES = 32,
    parameter int SLOT_W  = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    riscv_core_rob2w_if.slave   bus
);

    localparam logic [SLOT_W:0] c_FULL     = (SLOT_W+1)'(ENTRIES);
    localparam logic [SLOT_W:0] c_FULL_M1  = (SLOT_W+1)'(ENTRIES - 1);

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_pending;
    logic [ENTRIES-1:0] r_rd_en;
    logic [4:0]         r_rd [ENTRIES];
    logic [SLOT_W-1:0]  r_head;
    logic [SLOT_W-1:0]  r_tail;
    logic [SLOT_W:0]    r_count;

    logic [SLOT_W-1:0]  w_head1;
    logic [SLOT_W-1:0]  w_tail1;
    logic               w_alloc_A_rdy;
    logic               w_alloc_B_rdy;
    logic               w_do_A;
    logic               w_do_B;
    logic               w_commit_A;
    logic               w_commit_B;
    logic [1:0]         w_n_alloc;
    logic [1:0]         w_n_ret;

    // ENTRIES is a power of two, so natural SLOT_W-bit overflow is the wrap.
    assign w_head1 = r_head + SLOT_W'(1);
    assign w_tail1 = r_tail + SLOT_W'(1);

    // Readiness uses the pre-commit occupancy: slots retiring this cycle only
    // become reusable next cycle.
    assign w_alloc_A_rdy = (r_count < c_FULL);
    assign w_alloc_B_rdy = (r_count < c_FULL_M1);

    // B is always younger than A, so B alone is never allocated.
    assign w_do_A = bus.alloc_A_req & w_alloc_A_rdy;
    assign w_do_B = bus.alloc_B_req & bus.alloc_A_req & w_alloc_B_rdy;

    assign w_commit_A = r_valid[r_head] & ~r_pending[r_head];
    assign w_commit_B = w_commit_A & r_valid[w_head1] & ~r_pending[w_head1];

    assign w_n_alloc = {1'b0, w_do_A} + {1'b0, w_do_B};
    assign w_n_ret   = {1'b0, w_commit_A} + {1'b0, w_commit_B};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= '0;
            r_pending <= '0;
            r_rd_en   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_rd[i] <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            // Writeback completion; fills to unallocated slots are dropped.
            if (bus.fill_A_val && r_valid[bus.fill_A_slot]) begin
                r_pending[bus.fill_A_slot] <= 1'b0;
            end
            if (bus.fill_B_val && r_valid[bus.fill_B_slot]) begin
                r_pending[bus.fill_B_slot] <= 1'b0;
            end

            // Retirement. Retiring slots are valid and allocated slots are
            // not, so these never collide with the allocation writes below.
            if (w_commit_A) begin
                r_valid[r_head] <= 1'b0;
            end
            if (w_commit_B) begin
                r_valid[w_head1] <= 1'b0;
            end

            if (w_do_A) begin
                r_valid[r_tail]   <= 1'b1;
                r_pending[r_tail] <= 1'b1;
                r_rd[r_tail]      <= bus.alloc_A_rd;
                r_rd_en[r_tail]   <= bus.alloc_A_rd_en;
            end
            if (w_do_B) begin
                r_valid[w_tail1]   <= 1'b1;
                r_pending[w_tail1] <= 1'b1;
                r_rd[w_tail1]      <= bus.alloc_B_rd;
                r_rd_en[w_tail1]   <= bus.alloc_B_rd_en;
            end

            r_head  <= r_head + SLOT_W'(w_n_ret);
            r_tail  <= r_tail + SLOT_W'(w_n_alloc);
            r_count <= r_count + (SLOT_W+1)'(w_n_alloc) - (SLOT_W+1)'(w_n_ret);
        end
    end

    assign bus.alloc_A_slot   = r_tail;
    assign bus.alloc_B_slot   = w_tail1;
    assign bus.alloc_A_rdy    = w_alloc_A_rdy;
    assign bus.alloc_B_rdy    = w_alloc_B_rdy;

    assign bus.commit_A_ready = w_commit_A;
    assign bus.commit_A_slot  = r_head;
    assign bus.commit_A_rd    = w_commit_A ? r_rd[r_head] : 5'd0;
    assign bus.commit_A_rd_en = w_commit_A & r_rd_en[r_head];
    assign bus.commit_B_ready = w_commit_B;
    assign bus.commit_B_slot  = w_head1;
    assign bus.commit_B_rd    = w_commit_B ? r_rd[w_head1] : 5'd0;
    assign bus.commit_B_rd_en = w_commit_B & r_rd_en[w_head1];

    assign bus.empty = (r_count == '0);
    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_rob2w.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_core_rob2w
// Description : Self-checking bench for riscv_core_rob2w. Keeps an in-order
//               queue of outstanding instructions as the reference and checks
//               every DUT output each cycle, plus literal checks on directed
//               scenarios, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_rob2w;

    localparam int E  = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_core_rob2w_if #(.SLOT_W(SW)) bus ();

    riscv_core_rob2w #(.ENTRIES(E), .SLOT_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int slot;
        int rd;
        bit rd_en;
        bit done;
    } ent_t;

    ent_t q[$];      // outstanding instructions, oldest first
    int   m_head;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int sz;
        int tail;
        bit cA;
        bit cB;
        sz   = q.size();
        tail = (m_head + sz) % E;
        cA   = (sz >= 1) && q[0].done;
        cB   = cA && (sz >= 2) && q[1].done;
        chk("alloc_A_slot",   32'(bus.alloc_A_slot), tail);
        chk("alloc_B_slot",   32'(bus.alloc_B_slot), (tail + 1) % E);
        chk("alloc_A_rdy",    32'(bus.alloc_A_rdy), 32'(sz < E));
        chk("alloc_B_rdy",    32'(bus.alloc_B_rdy), 32'(sz <= E - 2));
        chk("commit_A_ready", 32'(bus.commit_A_ready), 32'(cA));
        chk("commit_B_ready", 32'(bus.commit_B_ready), 32'(cB));
        chk("commit_A_slot",  32'(bus.commit_A_slot), m_head);
        chk("commit_B_slot",  32'(bus.commit_B_slot), (m_head + 1) % E);
        chk("commit_A_rd",    32'(bus.commit_A_rd), cA ? q[0].rd : 0);
        chk("commit_A_rd_en", 32'(bus.commit_A_rd_en), cA ? 32'(q[0].rd_en) : 0);
        chk("commit_B_rd",    32'(bus.commit_B_rd), cB ? q[1].rd : 0);
        chk("commit_B_rd_en", 32'(bus.commit_B_rd_en), cB ? 32'(q[1].rd_en) : 0);
        chk("count",          32'(bus.count), sz);
        chk("empty",          32'(bus.empty), 32'(sz == 0));
    endtask

    task automatic model_update();
        int   sz;
        int   tail;
        int   nret;
        bit   doA;
        bit   doB;
        ent_t e;
        if (reset) begin
            q.delete();
            m_head = 0;
        end else begin
            sz   = q.size();
            tail = (m_head + sz) % E;
            doA  = bus.alloc_A_req && (sz < E);
            doB  = bus.alloc_B_req && bus.alloc_A_req && (sz <= E - 2);
            nret = 0;
            if (sz >= 1 && q[0].done) begin
                nret = 1;
                if (sz >= 2 && q[1].done) nret = 2;
            end
            foreach (q[i]) begin
                if (bus.fill_A_val && q[i].slot == int'(bus.fill_A_slot)) q[i].done = 1'b1;
                if (bus.fill_B_val && q[i].slot == int'(bus.fill_B_slot)) q[i].done = 1'b1;
            end
            repeat (nret) void'(q.pop_front());
            m_head = (m_head + nret) % E;
            if (doA) begin
                e.slot = tail; e.rd = int'(bus.alloc_A_rd); e.rd_en = bus.alloc_A_rd_en; e.done = 1'b0;
                q.push_back(e);
            end
            if (doB) begin
                e.slot = (tail + 1) % E; e.rd = int'(bus.alloc_B_rd); e.rd_en = bus.alloc_B_rd_en; e.done = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    // One clock: check current outputs, advance the reference with the
    // inputs presented this cycle, then move past the edge.
    task automatic step();
        @(negedge clk);
        compare_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit a, input int rda, input bit b, input int rdb,
                       input bit fa, input int sa, input bit fb, input int sb);
        bus.alloc_A_req   = a;
        bus.alloc_A_rd    = 5'(rda);
        bus.alloc_A_rd_en = 1'b1;
        bus.alloc_B_req   = b;
        bus.alloc_B_rd    = 5'(rdb);
        bus.alloc_B_rd_en = 1'b1;
        bus.fill_A_val    = fa;
        bus.fill_A_slot   = 5'(sa);
        bus.fill_B_val    = fb;
        bus.fill_B_slot   = 5'(sb);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.alloc_A_req = 0; bus.alloc_A_rd = 0; bus.alloc_A_rd_en = 0;
        bus.alloc_B_req = 0; bus.alloc_B_rd = 0; bus.alloc_B_rd_en = 0;
        bus.fill_A_val = 0; bus.fill_A_slot = 0; bus.fill_B_val = 0; bus.fill_B_slot = 0;
        q.delete();
        m_head = 0;
        // Bring the DUT out of its unknown power-up state before checking.
        @(posedge clk); #1;

        // Reset then idle
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_reset_empty", 32'(bus.empty), 1);
        chk("lit_reset_count", 32'(bus.count), 0);
        chk("lit_reset_aslot", 32'(bus.alloc_A_slot), 0);
        chk("lit_reset_bslot", 32'(bus.alloc_B_slot), 1);
        chk("lit_reset_rdy",   32'({bus.alloc_A_rdy, bus.alloc_B_rdy}), 3);
        chk("lit_reset_cA",    32'(bus.commit_A_ready), 0);

        // Dual allocate, out-of-order fills
        cyc(1, 3, 1, 7, 0, 0, 0, 0);
        chk("lit_dual_count", 32'(bus.count), 2);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("lit_dual_nocommit1", 32'(bus.commit_A_ready), 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_dual_cA", 32'({bus.commit_A_ready, bus.commit_A_slot, bus.commit_A_rd}), {1'b1, 5'd0, 5'd3});
        chk("lit_dual_cB", 32'({bus.commit_B_ready, bus.commit_B_slot, bus.commit_B_rd}), {1'b1, 5'd1, 5'd7});
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_dual_drain", 32'(bus.count), 0);

        // Three entries, two younger filled together
        do_reset();
        cyc(1, 4, 1, 5, 0, 0, 0, 0);
        cyc(1, 6, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2, 1, 1);
        chk("lit_three_nocommit", 32'(bus.commit_A_ready), 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_three_pair", 32'({bus.commit_A_ready, bus.commit_B_ready}), 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_three_single", 32'({bus.commit_A_ready, bus.commit_A_slot, bus.commit_B_ready}), {1'b1, 5'd2, 1'b0});
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Fill to occupancy
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1, i, 1, i + 1, 0, 0, 0, 0);
        cyc(1, 9, 0, 0, 0, 0, 0, 0);
        chk("lit_31_rdy", 32'({bus.alloc_A_rdy, bus.alloc_B_rdy}), 2);
        cyc(1, 9, 1, 9, 0, 0, 0, 0);
        chk("lit_full_count", 32'(bus.count), 32);
        chk("lit_full_rdyA",  32'(bus.alloc_A_rdy), 0);
        cyc(1, 9, 0, 0, 0, 0, 0, 0);
        chk("lit_full_tail", 32'({bus.count, bus.alloc_A_slot}), {6'd32, 5'd0});
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 9, 0, 0, 0, 0, 0, 0);
        chk("lit_precommit_refuse", 32'({bus.count, bus.alloc_A_slot}), {6'd31, 5'd0});
        cyc(1, 9, 0, 0, 0, 0, 0, 0);
        chk("lit_accept_next", 32'({bus.count, bus.alloc_A_slot}), {6'd32, 5'd1});

        // Wrap-around
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1, 1, 1, 2, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) cyc(0, 0, 0, 0, 1, 2 * k, 1, 2 * k + 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_wrap_pos", 32'({bus.count, bus.alloc_A_slot, bus.alloc_B_slot}), {6'd0, 5'd30, 5'd31});
        cyc(1, 10, 1, 11, 0, 0, 0, 0);
        chk("lit_wrap_slots", 32'({bus.alloc_A_slot, bus.alloc_B_slot}), {5'd0, 5'd1});
        cyc(1, 12, 1, 13, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 30, 1, 31);
        chk("lit_wrap_c1", 32'({bus.commit_A_slot, bus.commit_A_rd, bus.commit_B_slot, bus.commit_B_ready}),
            {5'd30, 5'd10, 5'd31, 1'b1});
        cyc(0, 0, 0, 0, 1, 0, 1, 1);
        chk("lit_wrap_c2", 32'({bus.commit_A_slot, bus.commit_A_rd, bus.commit_B_slot, bus.commit_B_ready}),
            {5'd0, 5'd12, 5'd1, 1'b1});
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_wrap_empty", 32'(bus.empty), 1);

        // Reset mid-operation together with a fill
        do_reset();
        cyc(1, 1, 1, 2, 0, 0, 0, 0);
        cyc(1, 3, 1, 4, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b0;
        chk("lit_rst_mid", 32'({bus.count, bus.empty, bus.commit_A_ready, bus.alloc_A_slot}),
            {6'd0, 1'b1, 1'b0, 5'd0});
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_nofill", 32'(bus.commit_A_ready), 0);

        // Randomized traffic; fill intensity alternates to sweep occupancy.
        for (int n = 0; n < 3000; n++) begin
            int fill_pct;
            fill_pct = ((n / 400) % 2 == 0) ? 25 : 85;
            reset = ($urandom_range(0, 599) == 0);
            bus.alloc_A_req   = ($urandom_range(0, 99) < 60);
            bus.alloc_B_req   = ($urandom_range(0, 99) < 50);
            bus.alloc_A_rd    = 5'($urandom);
            bus.alloc_A_rd_en = 1'($urandom);
            bus.alloc_B_rd    = 5'($urandom);
            bus.alloc_B_rd_en = 1'($urandom);
            bus.fill_A_val = 0; bus.fill_A_slot = 5'($urandom);
            bus.fill_B_val = 0; bus.fill_B_slot = 5'($urandom);
            if (q.size() > 0 && $urandom_range(0, 99) < fill_pct) begin
                bus.fill_A_val  = 1;
                bus.fill_A_slot = 5'(q[$urandom_range(0, q.size() - 1)].slot);
            end else if ($urandom_range(0, 99) < 15) begin
                bus.fill_A_val = 1;
            end
            if (q.size() > 0 && $urandom_range(0, 99) < fill_pct) begin
                bus.fill_B_val  = 1;
                bus.fill_B_slot = 5'(q[$urandom_range(0, q.size() - 1)].slot);
            end
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_core_rob2w.md
Name: riscv_core_rob2w

Overview:
- 2-wide reorder buffer for the in-order-issue, out-of-order-completion RISC-V core.
- Allocates ROB slots in program order at issue. These slots become the rd_A/rd_B tags tracked by the scoreboard.
- Marks slots complete on writeback.
- Retires up to two complete entries per cycle strictly in order. The retirement stream (slot, ready, arch dest) is the scoreboard's ROB commit input and the register-file write source.

Parameters:
- ENTRIES, 32, number of ROB slots; must equal 2^SLOT_W.
- SLOT_W, 5, slot index width.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- alloc_A_req  input  1  issue of older instruction (pipe A) requests a slot
- alloc_A_rd  input  5  architectural destination of A
- alloc_A_rd_en  input  1  A writes a register
- alloc_B_req  input  1  issue of younger instruction (pipe B) requests a slot
- alloc_B_rd  input  5  architectural destination of B
- alloc_B_rd_en  input  1  B writes a register
- alloc_A_slot  output  SLOT_W  slot granted to A (= tail)
- alloc_B_slot  output  SLOT_W  slot granted to B (= tail+1 mod ENTRIES)
- alloc_A_rdy  output  1  at least 1 free slot
- alloc_B_rdy  output  1  at least 2 free slots
- fill_A_val  input  1  writeback from pipe A completes
- fill_A_slot  input  SLOT_W  slot completed by A
- fill_B_val  input  1  writeback from pipe B completes
- fill_B_slot  input  SLOT_W  slot completed by B
- commit_A_ready  output  1  oldest entry retires this cycle
- commit_A_slot  output  SLOT_W  slot retiring (= head)
- commit_A_rd  output  5  its architectural dest
- commit_A_rd_en  output  1  its write enable
- commit_B_ready  output  1  second-oldest entry retires this cycle
- commit_B_slot  output  SLOT_W  head+1 mod ENTRIES
- commit_B_rd  output  5  its architectural dest
- commit_B_rd_en  output  1  its write enable
- empty  output  1  count==0
- count  output  SLOT_W+1  occupancy, 0..ENTRIES

Behaviour:
- State:
  - per-entry valid, pending, rd, rd_en
  - head, tail (SLOT_W, wrap modulo ENTRIES)
  - count (SLOT_W+1)
- Reset (synchronous, overrides everything in the same edge; also applies mid-operation):
  - head=tail=0, count=0, all valid=0, pending=0.
  - Outputs after reset: alloc_A_slot=0, alloc_B_slot=1, alloc_A_rdy=1, alloc_B_rdy=1, commit_A/B_ready=0, commit_A_slot=0, commit_B_slot=1, empty=1, count=0, commit_*_rd/rd_en=0.
- Allocation:
  - alloc_*_slot and alloc_*_rdy are combinational from registered state (zero latency), so issue can tag in the same cycle.
  - A allocates iff alloc_A_req && alloc_A_rdy.
  - B allocates iff alloc_B_req && alloc_A_req && alloc_B_rdy. B without A is ignored, because B is never older than A.
  - At the edge, each allocated entry gets valid=1, pending=1, rd/rd_en latched.
  - tail += number allocated (0/1/2).
  - rdy is computed from pre-commit count. Slots freed in the same cycle are not reusable until the next cycle.
- Fill:
  - At the edge, pending[fill_slot]=0 when fill_val && valid[fill_slot].
  - A fill to an invalid slot is ignored.
  - Both fills may target different slots in the same cycle.
  - Equal slots are legal and behave as a single fill.
- Commit:
  - Combinational from registered state.
  - commit_A_ready = valid[head] && !pending[head].
  - commit_B_ready = commit_A_ready && valid[head+1] && !pending[head+1].
  - No backpressure: a ready entry retires unconditionally.
  - At the edge, retired entries get valid=0 and head += number retired.
  - A fill arriving in the cycle its slot is head is not visible until the next cycle (1-cycle fill-to-commit latency).
  - commit_*_rd/rd_en are driven 0 when the corresponding ready is 0.
- Count and wrap:
  - count_next = count + allocated - retired. Simultaneous alloc and commit are legal.
  - Full is count==ENTRIES, at which point head==tail.
  - Slot indices wrap from ENTRIES-1 to 0 for both allocation and commit.
  - empty = (count==0).
- Requirement on issue: never issue an instruction while its rdy is 0. The ROB drops the request without side effects.

Test Plan:
- Reset then idle → empty=1, count=0, alloc_A_slot=0, alloc_B_slot=1, alloc_A_rdy=alloc_B_rdy=1, commit_A_ready=0.
- Dual-allocate A(rd=3) and B(rd=7) in one cycle.
  - Fill slot 1 in cycle 2, fill slot 0 in cycle 3.
  - Expect no commit through cycle 3.
  - Cycle 4: commit_A_slot=0/rd=3 and commit_B_slot=1/rd=7 both ready.
  - count goes 2→0.
- Allocate slots 0,1,2; fill 2 and 1 in the same cycle (A/B) → no commit. Then fill 0 → next cycle commits 0,1; the following cycle commits 2 alone (commit_B_ready=0).
- Fill occupancy:
  - Allocate 31 entries → alloc_A_rdy=1, alloc_B_rdy=0.
  - A dual request allocates only A → count=32, alloc_A_rdy=0, and a further request leaves tail unchanged.
  - Fill and commit head in the cycle of a new alloc request → request is still refused (pre-commit count), then accepted next cycle.
- Wrap: advance head/tail to 30 → dual alloc grants 30,31; next dual alloc grants 0,1; fills and commits retire 30,31,0,1 in order; slot 0 is committed after 31.
- Assert reset with 5 entries pending and fill_A_val=1 in the same cycle → next cycle count=0, empty=1, commit ready=0, alloc_A_slot=0; the fill has no effect.
